// File: rtl/prescaled_counter.sv
// Up/down event counter advanced by a programmable prescaler, with clear, load, tick and tc pulses.
// Define PRESCALED_COUNTER_SAT_EN to saturate at the count limits instead of wrapping.
module prescaled_counter #(
    parameter int WIDTH    = 4,
    parameter int PS_WIDTH = 26
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                clear,
    input  logic                load,
    input  logic [WIDTH-1:0]    load_value,
    input  logic                up_down,
    input  logic [PS_WIDTH-1:0] div_value,
    output logic [WIDTH-1:0]    count_out,
    output logic                tick,
    output logic                tc
);

    localparam logic [WIDTH-1:0]    COUNT_ONE = WIDTH'(1);
    localparam logic [PS_WIDTH-1:0] PS_ONE    = PS_WIDTH'(1);

    logic [PS_WIDTH-1:0] ps_cnt;
    logic                expiry;
    logic                at_limit;
    logic [WIDTH-1:0]    step_value;
    logic [WIDTH-1:0]    next_count;

    // A >= compare lets a lowered div_value take effect at once instead of
    // waiting for the prescaler to wrap all the way around.
    always_comb begin
        expiry     = ps_cnt >= div_value;
        at_limit   = up_down ? (count_out == '1) : (count_out == '0);
        step_value = up_down ? (count_out + COUNT_ONE) : (count_out - COUNT_ONE);
`ifdef PRESCALED_COUNTER_SAT_EN
        next_count = at_limit ? count_out : step_value;
`else
        next_count = step_value;
`endif
    end

    // In both builds tc marks an expiry taken at the limit: a wrap or a blocked step.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_out <= '0;
            ps_cnt    <= '0;
            tick      <= 1'b0;
            tc        <= 1'b0;
        end else if (clear) begin
            count_out <= '0;
            ps_cnt    <= '0;
            tick      <= 1'b0;
            tc        <= 1'b0;
        end else if (load) begin
            count_out <= load_value;
            ps_cnt    <= '0;
            tick      <= 1'b0;
            tc        <= 1'b0;
        end else if (!enable) begin
            tick <= 1'b0;
            tc   <= 1'b0;
        end else if (expiry) begin
            count_out <= next_count;
            ps_cnt    <= '0;
            tick      <= 1'b1;
            tc        <= at_limit;
        end else begin
            ps_cnt <= ps_cnt + PS_ONE;
            tick   <= 1'b0;
            tc     <= 1'b0;
        end
    end

endmodule

// File: doc/prescaled_counter.md
# prescaled_counter

- Parametrised up/down event counter driven by an internal programmable prescaler.
- Counts in steps of one, once every `div_value+1` enabled clocks. Supports synchronous clear and parallel load.
- Emits single-cycle `tick` (prescaler expiry) and `tc` (terminal count) pulses.
- Serves as the general-purpose slow counter for display, LED and timeout logic. It replaces fixed-width, fixed-divide counters.

## Interface
- `WIDTH`, default 4: counter width in bits.
- `PS_WIDTH`, default 26: prescaler width in bits.
- `clock` input, 1 bit: single clock; all state updates on the rising edge.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `enable` input, 1 bit: active-high. When low, the prescaler and counter hold.
- `clear` input, 1 bit: synchronous clear of the counter and prescaler.
- `load` input, 1 bit: synchronous parallel load.
- `load_value` input, `WIDTH` bits: value written on `load`.
- `up_down` input, 1 bit: 1 = count up, 0 = count down.
- `div_value` input, `PS_WIDTH` bits: the prescaler expires after `div_value+1` enabled clocks.
- `count_out` output, `WIDTH` bits: current count (registered).
- `tick` output, 1 bit: registered one-cycle pulse for each counter step.
- `tc` output, 1 bit: registered one-cycle pulse at wrap (or at saturation, see Configuration).

## Operation
- **Internal state:** prescaler `ps_cnt[PS_WIDTH-1:0]`.
- **Per-edge priority:** clear > load > disabled hold > prescaler/step.
- **clear = 1:**
  - `count_out`←0, `ps_cnt`←0, `tick`←0, `tc`←0.
  - Acts regardless of `enable`.
- **load = 1 (clear = 0):**
  - `count_out`←`load_value`, `ps_cnt`←0, `tick`←0, `tc`←0.
  - Acts regardless of `enable`.
  - A load coincident with prescaler expiry suppresses the step.
- **enable = 0:** `count_out` and `ps_cnt` hold; `tick`←0, `tc`←0.
- **enable = 1, `ps_cnt < div_value`:** `ps_cnt`←`ps_cnt+1`; `tick`←0, `tc`←0.
- **enable = 1, `ps_cnt >= div_value` (expiry):** `ps_cnt`←0, `tick`←1, then step:
  - Up: `count_out`←`count_out+1`. Stepping from `2^WIDTH-1` wraps to 0 and sets `tc`←1.
  - Down: `count_out`←`count_out-1`. Stepping from 0 wraps to `2^WIDTH-1` and sets `tc`←1.
- **Expiry compare is `>=`.** Lowering `div_value` below the current `ps_cnt` forces expiry at the next enabled edge, with no long wrap of the prescaler.
- **`div_value` = 0:** step on every enabled clock.
- **Arithmetic:** modulo `2^WIDTH` for the counter and modulo `2^PS_WIDTH` for the prescaler. No other overflow paths exist.
- **Sampling:** `up_down` is sampled only at expiry; changing it between steps is legal.

## Timing
- **Reset:** `reset_n` low asynchronously forces `count_out`=0, `ps_cnt`=0, `tick`=0, `tc`=0. This holds mid-count, independent of `clock`.
- **Reset release:** the first rising edge with `reset_n` high is the first active edge. The design applies no reset synchroniser internally; that is the integrator's responsibility.
- **Step period:** with `enable` held high from reset release, `count_out` first changes at active edge `div_value+1`, then every `div_value+1` edges.
- **`tick` and `tc` timing:** both are high for exactly the one cycle following the stepping edge and are never high for two consecutive cycles unless `div_value`=0.
- **Load/clear latency:** the effect is visible on `count_out` one edge after assertion. The prescaler restarts from 0, so the next step is `div_value+1` enabled edges later.
- **Combinational paths:** none from inputs to outputs.

## Configuration
- **Macro:** `PRESCALED_COUNTER_SAT_EN`.
- **Defined:**
  - Counting saturates instead of wrapping. Up at `2^WIDTH-1` holds; down at 0 holds.
  - `tc`←1 on every expiry where the step was blocked at the limit. `tick` still pulses.
  - A step that merely reaches the limit does not assert `tc`.
- **Undefined:** wrap behaviour as described in Operation.
- **Scope:** the port list is identical in both builds.

## Test plan
- **Basic up-count:** `WIDTH`=4, `div_value`=3, `up_down`=1, `enable`=1 from reset → `count_out`=1 after edge 4, 2 after edge 8. `tick` is high in cycles 5 and 9 only.
- **Wrap up:** load 15, `div_value`=0, up → next edge gives 0 with `tc`=1 for one cycle. The SAT build instead holds 15 with `tc` pulsing every cycle.
- **Wrap down:** load 0, `div_value`=0, `up_down`=0 → 15 with `tc`=1. The SAT build holds 0 with `tc`=1.
- **Priority:** assert `clear`, `load` (`load_value`=9) and expiry on the same edge → `count_out`=0, `tick`=0. Then `load` with expiry → 9, no step, `tick`=0.
- **Hold and retune:** drop `enable` for 10 cycles mid-count → `count_out` and `tick` are frozen. With `ps_cnt`=20 and `div_value`=100 changed to 5 → step on the next enabled edge.
- **Async reset:** pulse `reset_n` low between clock edges at count 7 → `count_out`, `tick` and `tc` go to 0 immediately. Counting restarts with the first step at edge `div_value+1`.
